pipelined_cla_adder: RTL

- Parametrised, pipelined carry-lookahead adder/subtractor for wide datapaths.
- Operand width is split into STAGES pipeline slices. Each slice is built from BLK-bit lookahead groups with a second-level lookahead across groups.
- Carries ripple between slices through pipeline registers.
- Sits between operand producers and ALU/accumulator consumers. Uses a valid/ready handshake with one result per cycle sustained throughput.

---
 rtl/cla_pkg.sv | 26 ++
 rtl/cla_group.sv | 52 +++++
 rtl/pipelined_cla_adder.sv | 135 +++++++++++++
 3 files changed

// File: rtl/cla_pkg.sv
// Shared configuration helpers for the pipelined carry-lookahead adder.
package cla_pkg;

  // Legal when the operand splits evenly into slices and each slice
  // splits evenly into lookahead groups.
  function automatic bit cla_cfg_ok(input int width, input int stages, input int blk);
    bit ok;
    ok = (stages >= 1) && (blk >= 1) && (width >= stages);
    if (ok) ok = ((width % stages) == 0) && (((width / stages) % blk) == 0);
    return ok;
  endfunction

  // Bits handled by one pipeline stage.
  function automatic int cla_slice_w(input int width, input int stages);
    return (stages >= 1) ? (width / stages) : width;
  endfunction

  // Lookahead groups inside one stage (at least one, even for bad configs,
  // so elaboration reaches the configuration error instead of a zero width).
  function automatic int cla_groups(input int width, input int stages, input int blk);
    int sw;
    sw = cla_slice_w(width, stages);
    return (blk >= 1 && sw >= blk) ? (sw / blk) : 1;
  endfunction

endpackage

// File: rtl/cla_group.sv
// BLK-bit carry-lookahead group: local sum bits plus group propagate/generate
// for the second-level lookahead in the parent.
module cla_group #(
  parameter int BLK = 4
) (
  input  logic [BLK-1:0] i_p,
  input  logic [BLK-1:0] i_g,
  input  logic           i_cin,
  output logic [BLK-1:0] o_sum,
  output logic           o_pg,
  output logic           o_gg
);

  logic [BLK-1:0] w_c;

  // Carry into each bit, expanded in lookahead form from the group carry-in.
  always_comb begin
    logic v_carry;
    logic v_term;
    v_carry = 1'b0;
    v_term  = 1'b0;
    w_c     = '0;
    for (int i = 0; i < BLK; i++) begin
      v_carry = i_cin;
      for (int m = 0; m < i; m++) v_carry = v_carry & i_p[m];
      for (int n = 0; n < i; n++) begin
        v_term = i_g[n];
        for (int m = n + 1; m < i; m++) v_term = v_term & i_p[m];
        v_carry = v_carry | v_term;
      end
      w_c[i] = v_carry;
    end
  end

  // Group generate: some bit generates and every bit above it propagates.
  always_comb begin
    logic v_gen;
    logic v_term;
    v_gen  = 1'b0;
    v_term = 1'b0;
    for (int n = 0; n < BLK; n++) begin
      v_term = i_g[n];
      for (int m = n + 1; m < BLK; m++) v_term = v_term & i_p[m];
      v_gen = v_gen | v_term;
    end
    o_gg = v_gen;
  end

  assign o_sum = i_p ^ w_c;
  assign o_pg  = &i_p;

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor. Each stage resolves one
// WIDTH/STAGES slice; the slice carry-out is registered and feeds the next
// stage. Upper operand bits travel with the operation, finished sum bits
// accumulate in sum_done. The last stage register is the output register.
module pipelined_cla_adder
  import cla_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4,
  parameter int BLK    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int SW = cla_slice_w(WIDTH, STAGES);
  localparam int NG = cla_groups(WIDTH, STAGES, BLK);

  typedef struct packed {
    logic             valid;
    logic             carry;
    logic             ovf;
    logic [WIDTH-1:0] a_rem;
    logic [WIDTH-1:0] b_rem;
    logic [WIDTH-1:0] sum_done;
  } stage_t;

  if (!cla_cfg_ok(WIDTH, STAGES, BLK)) begin : g_cfg_check
    $error("pipelined_cla_adder: WIDTH/STAGES/BLK combination is not legal");
  end

  stage_t r_stage     [STAGES];
  stage_t w_stage_out [STAGES];
  logic   w_adv;

  // The whole pipe moves together; it only stalls when a result is waiting.
  assign w_adv     = ~r_stage[STAGES-1].valid | out_ready;
  assign in_ready  = w_adv;
  assign out_valid = r_stage[STAGES-1].valid;
  assign sum       = r_stage[STAGES-1].sum_done;
  assign cout      = r_stage[STAGES-1].carry;
  assign ovf       = r_stage[STAGES-1].ovf;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    stage_t        w_in;
    stage_t        w_out;
    logic [SW-1:0] w_p;
    logic [SW-1:0] w_g;
    logic [SW-1:0] w_s;
    logic [NG-1:0] w_pg;
    logic [NG-1:0] w_gg;
    logic [NG:0]   w_cgrp;

    if (k == 0) begin : g_entry
      // Entry stage: fold subtract into inverted B with forced carry-in.
      always_comb begin
        w_in          = '0;
        w_in.valid    = in_valid;
        w_in.carry    = sub ? 1'b1 : cin;
        w_in.a_rem    = a;
        w_in.b_rem    = sub ? ~b : b;
      end
    end else begin : g_link
      assign w_in = r_stage[k-1];
    end

    assign w_p = w_in.a_rem[k*SW +: SW] ^ w_in.b_rem[k*SW +: SW];
    assign w_g = w_in.a_rem[k*SW +: SW] & w_in.b_rem[k*SW +: SW];

    for (genvar j = 0; j < NG; j++) begin : g_grp
      cla_group #(
        .BLK(BLK)
      ) u_grp (
        .i_p  (w_p[j*BLK +: BLK]),
        .i_g  (w_g[j*BLK +: BLK]),
        .i_cin(w_cgrp[j]),
        .o_sum(w_s[j*BLK +: BLK]),
        .o_pg (w_pg[j]),
        .o_gg (w_gg[j])
      );
    end

    // Second-level lookahead: carry into each group from the slice carry-in.
    always_comb begin
      logic v_carry;
      logic v_term;
      v_carry   = 1'b0;
      v_term    = 1'b0;
      w_cgrp    = '0;
      w_cgrp[0] = w_in.carry;
      for (int j = 1; j <= NG; j++) begin
        v_carry = w_in.carry;
        for (int i = 0; i < j; i++) v_carry = v_carry & w_pg[i];
        for (int i = 0; i < j; i++) begin
          v_term = w_gg[i];
          for (int m = i + 1; m < j; m++) v_term = v_term & w_pg[m];
          v_carry = v_carry | v_term;
        end
        w_cgrp[j] = v_carry;
      end
    end

    // Next record: slice result merged in; carry into the slice MSB is
    // recovered as sum^p, which only matters for ovf in the final stage.
    always_comb begin
      w_out                        = w_in;
      w_out.carry                  = w_cgrp[NG];
      w_out.ovf                    = (w_s[SW-1] ^ w_p[SW-1]) ^ w_cgrp[NG];
      w_out.sum_done[k*SW +: SW]   = w_s;
    end

    assign w_stage_out[k] = w_out;
  end

  // Stage registers: clear on reset, otherwise shift in lockstep on advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) r_stage[k] <= '0;
    end else if (w_adv) begin
      for (int k = 0; k < STAGES; k++) r_stage[k] <= w_stage_out[k];
    end
  end

endmodule
